// File: rtl/pll_spi_master.sv
// SPI mode-0 initiator for the PLL digital core configuration port.
// Each packet is {ctrl, data}, sent MSB first. miso is captured into a
// readback word that is published in the cycle ss returns high.
//
// Ports
//   clk      system clock
//   rst      synchronous reset, active high
//   start    packet request, only looked at while idle
//   ctrl     control field, packet bits [DATA_WIDTH-1 -: 4]
//   data     data field, packet bits [DATA_WIDTH-5:0]
//   busy     high from packet acceptance until the FSM is idle again
//   done     one-cycle pulse in the cycle ss returns high
//   rx_data  miso bits captured during the last completed packet
//   sclk     SPI clock, idles low
//   ss       slave select, active low
//   mosi     serial data to the slave
//   miso     serial data from the slave
//
// state | meaning
// IDLE  | waiting for start; ss high, sclk low
// SETUP | ss low, first bit on mosi, sclk held low
// SHIFT | sclk toggling every CLK_DIV cycles; rx on fall, tx on fall
// HOLD  | ss still low after the last sclk low half-period
// GAP   | ss high, busy high, enforces the inter-packet gap

module pll_spi_master #(
   parameter int CLK_DIV    = 2,
   parameter int SETUP_CYC  = 2,
   parameter int HOLD_CYC   = 2,
   parameter int GAP_CYC    = 4,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [3:0]            ctrl,
   input  logic [DATA_WIDTH-5:0] data,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  sclk,
   output logic                  ss,
   output logic                  mosi,
   input  logic                  miso
);

   localparam int MAX_A   = (CLK_DIV > SETUP_CYC) ? CLK_DIV : SETUP_CYC;
   localparam int MAX_B   = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
   localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
   localparam int BIT_W   = $clog2(DATA_WIDTH + 1);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0] ALL_BITS = BIT_W'(DATA_WIDTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } state_t;

   state_t                state, state_n;
   logic [CNT_W-1:0]      cnt, cnt_n;
   logic [BIT_W-1:0]      bit_cnt, bit_cnt_n;
   logic [DATA_WIDTH-1:0] tx_shift, tx_shift_n;
   logic [DATA_WIDTH-1:0] rx_shift, rx_shift_n;
   logic [DATA_WIDTH-1:0] rx_data_n;
   logic                  busy_n, done_n, sclk_n, ss_n, mosi_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
         rx_data  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sclk     <= 1'b0;
         ss       <= 1'b1;
         mosi     <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         bit_cnt  <= bit_cnt_n;
         tx_shift <= tx_shift_n;
         rx_shift <= rx_shift_n;
         rx_data  <= rx_data_n;
         busy     <= busy_n;
         done     <= done_n;
         sclk     <= sclk_n;
         ss       <= ss_n;
         mosi     <= mosi_n;
      end
   end

   // Every output is computed here as a next value and registered above.
   // The final sclk low half-period stays inside SHIFT, so ss low spans
   // SETUP_CYC + 2*DATA_WIDTH*CLK_DIV + HOLD_CYC cycles.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      bit_cnt_n  = bit_cnt;
      tx_shift_n = tx_shift;
      rx_shift_n = rx_shift;
      rx_data_n  = rx_data;
      busy_n     = busy;
      done_n     = 1'b0;
      sclk_n     = sclk;
      ss_n       = ss;
      mosi_n     = mosi;

      unique case (state)
         ST_IDLE: begin
            if (start) begin
               tx_shift_n = {ctrl, data};
               rx_shift_n = '0;
               bit_cnt_n  = '0;
               mosi_n     = ctrl[3];
               ss_n       = 1'b0;
               busy_n     = 1'b1;
               cnt_n      = SETUP_LD;
               state_n    = ST_SETUP;
            end
         end

         ST_SETUP: begin
            if (cnt == '0) begin
               sclk_n  = 1'b1;
               cnt_n   = HALF_LD;
               state_n = ST_SHIFT;
            end else begin
               cnt_n = cnt - CNT_ONE;
            end
         end

         ST_SHIFT: begin
            if (cnt == '0) begin
               cnt_n = HALF_LD;
               if (sclk) begin
                  sclk_n     = 1'b0;
                  rx_shift_n = {rx_shift[DATA_WIDTH-2:0], miso};
                  bit_cnt_n  = bit_cnt + BIT_ONE;
                  tx_shift_n = {tx_shift[DATA_WIDTH-2:0], 1'b0};
                  mosi_n     = (bit_cnt == LAST_BIT) ? 1'b0 : tx_shift[DATA_WIDTH-2];
               end else if (bit_cnt == ALL_BITS) begin
                  cnt_n   = HOLD_LD;
                  state_n = ST_HOLD;
               end else begin
                  sclk_n = 1'b1;
               end
            end else begin
               cnt_n = cnt - CNT_ONE;
            end
         end

         ST_HOLD: begin
            if (cnt == '0) begin
               ss_n      = 1'b1;
               rx_data_n = rx_shift;
               done_n    = 1'b1;
               cnt_n     = GAP_LD;
               state_n   = ST_GAP;
            end else begin
               cnt_n = cnt - CNT_ONE;
            end
         end

         ST_GAP: begin
            if (cnt == '0) begin
               busy_n  = 1'b0;
               state_n = ST_IDLE;
            end else begin
               cnt_n = cnt - CNT_ONE;
            end
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_pll_spi_master.sv
module tb_pll_spi_master;

   logic        clk = 1'b0;
   logic        rst;

   logic        start_a, busy_a, done_a, sclk_a, ss_a, mosi_a, miso_a;
   logic [3:0]  ctrl_a;
   logic [11:0] data_a;
   logic [15:0] rx_a;
   logic        loop_a, miso_val_a;

   logic        start_b, busy_b, done_b, sclk_b, ss_b, mosi_b, miso_b;
   logic [3:0]  ctrl_b;
   logic [11:0] data_b;
   logic [15:0] rx_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign miso_a = loop_a ? mosi_a : miso_val_a;
   assign miso_b = mosi_b;

   pll_spi_master dut_a (
      .clk(clk), .rst(rst), .start(start_a), .ctrl(ctrl_a), .data(data_a),
      .busy(busy_a), .done(done_a), .rx_data(rx_a), .sclk(sclk_a),
      .ss(ss_a), .mosi(mosi_a), .miso(miso_a)
   );

   pll_spi_master #(.CLK_DIV(1), .SETUP_CYC(1), .HOLD_CYC(1), .GAP_CYC(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .ctrl(ctrl_b), .data(data_b),
      .busy(busy_b), .done(done_b), .rx_data(rx_b), .sclk(sclk_b),
      .ss(ss_b), .mosi(mosi_b), .miso(miso_b)
   );

   // bus monitor for dut_a
   int          rises_a = 0, dones_a = 0, viol_a = 0;
   int          run_lo_a = 0, run_hi_a = 0, run_busy_a = 0;
   int          last_ss_low_a = 0, last_ss_high_a = 0, last_busy_a = 0;
   logic [15:0] mosi_word_a = '0;
   logic        p_sclk_a = 1'b0, p_mosi_a = 1'b0, p_ss_a = 1'b1, p_busy_a = 1'b0;

   always @(negedge clk) begin
      if (sclk_a === 1'b1 && p_sclk_a === 1'b0) begin
         rises_a     <= rises_a + 1;
         mosi_word_a <= {mosi_word_a[14:0], mosi_a};
      end
      if (sclk_a === 1'b1 && mosi_a !== p_mosi_a) viol_a <= viol_a + 1;
      if (ss_a === 1'b0) run_lo_a <= run_lo_a + 1; else run_lo_a <= 0;
      if (ss_a === 1'b1) run_hi_a <= run_hi_a + 1; else run_hi_a <= 0;
      if (ss_a === 1'b1 && p_ss_a === 1'b0) last_ss_low_a <= run_lo_a;
      if (ss_a === 1'b0 && p_ss_a === 1'b1) last_ss_high_a <= run_hi_a;
      if (busy_a === 1'b1) run_busy_a <= run_busy_a + 1; else run_busy_a <= 0;
      if (busy_a === 1'b0 && p_busy_a === 1'b1) last_busy_a <= run_busy_a;
      if (done_a === 1'b1) dones_a <= dones_a + 1;
      p_sclk_a <= sclk_a;
      p_mosi_a <= mosi_a;
      p_ss_a   <= ss_a;
      p_busy_a <= busy_a;
   end

   // bus monitor for dut_b
   int   rises_b = 0, run_lo_b = 0, last_ss_low_b = 0;
   logic p_sclk_b = 1'b0, p_ss_b = 1'b1;

   always @(negedge clk) begin
      if (sclk_b === 1'b1 && p_sclk_b === 1'b0) rises_b <= rises_b + 1;
      if (ss_b === 1'b0) run_lo_b <= run_lo_b + 1; else run_lo_b <= 0;
      if (ss_b === 1'b1 && p_ss_b === 1'b0) last_ss_low_b <= run_lo_b;
      p_sclk_b <= sclk_b;
      p_ss_b   <= ss_b;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_a(input logic [3:0] c, input logic [11:0] d);
      start_a = 1'b1;
      ctrl_a  = c;
      data_a  = d;
      tick();
      start_a = 1'b0;
   endtask

   task automatic wait_done_a(input string tag);
      int n = 0;
      while (done_a !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      chk(tag, done_a, 1'b1);
   endtask

   task automatic wait_idle_a(input string tag);
      int n = 0;
      while (busy_a !== 1'b0 && n < 300) begin
         tick();
         n++;
      end
      chk(tag, busy_a, 1'b0);
   endtask

   task automatic wait_ss_low_a(input string tag);
      int n = 0;
      while (ss_a !== 1'b0 && n < 300) begin
         tick();
         n++;
      end
      chk(tag, ss_a, 1'b0);
   endtask

   task automatic run_b(input logic [3:0] c, input logic [11:0] d, input logic [15:0] exp_rx);
      int n = 0;
      int r0;
      r0      = rises_b;
      start_b = 1'b1;
      ctrl_b  = c;
      data_b  = d;
      tick();
      start_b = 1'b0;
      while (done_b !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk("b_done_seen", done_b, 1'b1);
      chk("b_rx_data", rx_b, exp_rx);
      chk("b_ss_low", last_ss_low_b, 34);
      chk("b_sclk_rises", rises_b - r0, 16);
      repeat (4) tick();
   endtask

   initial begin
      int r0, d0;
      rst        = 1'b1;
      start_a    = 1'b0;
      ctrl_a     = '0;
      data_a     = '0;
      loop_a     = 1'b0;
      miso_val_a = 1'b0;
      start_b    = 1'b0;
      ctrl_b     = '0;
      data_b     = '0;
      repeat (3) tick();

      chk("rst_ss", ss_a, 1'b1);
      chk("rst_sclk", sclk_a, 1'b0);
      chk("rst_mosi", mosi_a, 1'b0);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_done", done_a, 1'b0);
      chk("rst_rx", rx_a, 16'h0000);
      rst = 1'b0;
      repeat (2) tick();

      // basic packet, miso held low
      r0 = rises_a;
      d0 = dones_a;
      pulse_a(4'b0100, 12'h03F);
      chk("busy_after_accept", busy_a, 1'b1);
      wait_done_a("p1_done_seen");
      chk("p1_mosi_word", mosi_word_a, 16'h403F);
      chk("p1_ss_low", last_ss_low_a, 68);
      wait_idle_a("p1_idle");
      chk("p1_busy_len", last_busy_a, 72);
      chk("p1_rises", rises_a - r0, 16);
      chk("p1_dones", dones_a - d0, 1);
      chk("p1_rx", rx_a, 16'h0000);
      chk("p1_mosi_mode0", viol_a, 0);

      // loopback readback, then miso tied high
      loop_a = 1'b1;
      pulse_a(4'b0101, 12'h040);
      wait_done_a("p2_done_seen");
      chk("p2_rx_loop", rx_a, 16'h5040);
      wait_idle_a("p2_idle");
      repeat (10) tick();
      chk("p2_rx_hold", rx_a, 16'h5040);
      loop_a     = 1'b0;
      miso_val_a = 1'b1;
      pulse_a(4'b0000, 12'h000);
      wait_done_a("p3_done_seen");
      chk("p3_rx_ones", rx_a, 16'hFFFF);
      wait_idle_a("p3_idle");

      // start while busy is ignored, and ctrl/data are not resampled
      miso_val_a = 1'b0;
      r0 = rises_a;
      d0 = dones_a;
      pulse_a(4'b1010, 12'h5A5);
      ctrl_a = 4'b0001;
      data_a = 12'h234;
      repeat (9) tick();
      pulse_a(4'b1111, 12'hFFF);
      repeat (29) tick();
      pulse_a(4'b0011, 12'h333);
      wait_done_a("p4_done_seen");
      chk("p4_mosi_word", mosi_word_a, 16'hA5A5);
      repeat (30) tick();
      chk("p4_rises", rises_a - r0, 16);
      chk("p4_dones", dones_a - d0, 1);
      chk("p4_idle", busy_a, 1'b0);

      // start held high: four back-to-back packets
      loop_a = 1'b1;
      r0 = rises_a;
      d0 = dones_a;
      start_a = 1'b1;
      ctrl_a  = 4'b0110;
      data_a  = 12'hFFF;
      for (int k = 0; k < 4; k++) begin
         wait_ss_low_a("b2b_ss_low_seen");
         if (k > 0) chk("b2b_ss_high_gap", last_ss_high_a, 5);
         if (k == 3) start_a = 1'b0;
         wait_done_a("b2b_done_seen");
      end
      wait_idle_a("b2b_idle");
      repeat (10) tick();
      chk("b2b_dones", dones_a - d0, 4);
      chk("b2b_rises", rises_a - r0, 64);
      chk("b2b_rx", rx_a, 16'h6FFF);
      chk("b2b_ss_low", last_ss_low_a, 68);

      // reset mid-packet
      d0 = dones_a;
      pulse_a(4'b0011, 12'hABC);
      repeat (29) tick();
      chk("mid_ss_low", ss_a, 1'b0);
      rst = 1'b1;
      tick();
      chk("mid_rst_ss", ss_a, 1'b1);
      chk("mid_rst_sclk", sclk_a, 1'b0);
      chk("mid_rst_mosi", mosi_a, 1'b0);
      chk("mid_rst_busy", busy_a, 1'b0);
      chk("mid_rst_rx", rx_a, 16'h0000);
      chk("mid_rst_done", done_a, 1'b0);
      rst = 1'b0;
      repeat (10) tick();
      chk("mid_rst_no_done", dones_a - d0, 0);
      r0 = rises_a;
      pulse_a(4'b1100, 12'h000);
      wait_done_a("p6_done_seen");
      chk("p6_rx_loop", rx_a, 16'hC000);
      chk("p6_rises", rises_a - r0, 16);
      wait_idle_a("p6_idle");

      // fastest timing configuration
      run_b(4'b1000, 12'h000, 16'h8000);
      run_b(4'b1001, 12'hA5C, 16'h9A5C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
